mem_port_arbiter: RTL

//  Shares one unified single-port memory between the IF stage (instruction fetch) and the MEM stage (load/store).

---
 rtl/mips_pkg.sv | 19 +
 rtl/arb_watchdog.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the unified-memory port arbiter.
//   arb_state_t  : arbiter FSM states (IDLE, data grant, fetch grant)
//   ADDR_W_DEF   : default address width
//   DATA_W_DEF   : default data width
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_D = 2'd1,
        GNT_I = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// -----------------------------------------------------------------------------
// arb_watchdog
// Counts cycles spent in a grant state and flags the cycle in which the
// TIMEOUT_CYC-th grant cycle elapses without the memory completing.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clr        : restart the count (idle or command completing this cycle)
//   en         : a command is outstanding this cycle
//   timeout    : this is the last allowed cycle of the current command
// -----------------------------------------------------------------------------
module arb_watchdog
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    // The counter holds the number of grant cycles already completed, so it
    // only needs to reach TIMEOUT_CYC-1.
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = en && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between instruction fetch (IF) and the
// load/store stage (MEM). Data requests win ties; after a data access a
// pending fetch is served next so fetch cannot starve. A watchdog aborts
// accesses the memory never completes and sets a sticky error flag.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   if_req/if_addr             : fetch request (level, held until if_valid)
//   if_rdata/if_valid          : fetched word / one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata : data request (level, held until dm_valid)
//   dm_rdata/dm_valid          : load word / one-cycle completion pulse
//   stall_if/stall_mem         : combinational stall requests to the pipeline
//   mem_en/mem_we/mem_addr/mem_wdata : registered memory command
//   mem_rdata/mem_ready        : memory response
//   err                        : sticky watchdog-timeout flag
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    arb_state_t        state_q, state_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_valid_q, if_valid_d;
    logic              dm_valid_q, dm_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              err_q, err_d;

    logic              wdog_timeout;
    logic              busy;
    logic              done;
    logic              req_d;
    logic              req_i;
    logic              take_d;
    logic              take_i;
    logic [DATA_W-1:0] rsp_data;

    // A requester is masked in its own valid cycle: its req is still high
    // there but belongs to the transaction that just finished.
    assign req_d = dm_req && !dm_valid_q;
    assign req_i = if_req && !if_valid_q;

    assign busy = (state_q != IDLE);
    // A watchdog abort completes the command exactly like mem_ready would.
    assign done = busy && (mem_ready || wdog_timeout);
    assign rsp_data = mem_ready ? mem_rdata : '0;

    // A new grant may start in IDLE or on the completing edge (back-to-back).
    // The port that is completing is masked, so data never takes two grants
    // in a row while a fetch is waiting.
    assign take_d = (!busy || done) && req_d && (state_q != GNT_D);
    assign take_i = (!busy || done) && !take_d && req_i && (state_q != GNT_I);

    arb_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (!busy || done),
        .en     (busy),
        .timeout(wdog_timeout)
    );

    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        err_d       = err_q;

        if (done) begin
            if (state_q == GNT_D) begin
                dm_valid_d = 1'b1;
                // Stores leave the last load result visible.
                if (!mem_we_q) begin
                    dm_rdata_d = rsp_data;
                end
            end else begin
                if_valid_d = 1'b1;
                if_rdata_d = rsp_data;
            end
            if (!mem_ready) begin
                err_d = 1'b1;
            end
            state_d  = IDLE;
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
        end

        if (take_d) begin
            state_d     = GNT_D;
            mem_en_d    = 1'b1;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
        end else if (take_i) begin
            state_d    = GNT_I;
            mem_en_d   = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            err_q       <= err_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign err       = err_q;

    assign stall_if  = if_req && !if_valid_q;
    assign stall_mem = dm_req && !dm_valid_q;

endmodule
